key_setpoint: RTL and testbench

Consumer of the debounced key pulses in the temperature controller. Takes the three debounced key outputs (mode, up, down), runs a setpoint edit session, and holds the committed target temperature used by the control loop and display. It turns multi-cycle key pulses into single actions and provides an edit value, an edit flag and a blink strobe for the display driver.

---
 rtl/temp_ctrl_pkg.sv | 16 +
 rtl/key_setpoint_if.sv | 24 ++
 rtl/key_edge_det.sv | 23 ++
 rtl/key_setpoint.sv | 166 ++++++++++++++++
 tb/tb_key_setpoint.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/temp_ctrl_pkg.sv
// Shared temperature-controller definitions: setpoint width/range defaults
// and the setpoint edit-session state encoding.
package temp_ctrl_pkg;

  localparam int SP_W_DEF       = 8;
  localparam int SP_MIN_DEF     = 0;
  localparam int SP_MAX_DEF     = 99;
  localparam int SP_DEFAULT_DEF = 25;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } sp_state_e;

endpackage

// File: rtl/key_setpoint_if.sv
// Key-pulse inputs and setpoint/display outputs of key_setpoint.
// The master side drives the keys; the slave side is the setpoint block.
interface key_setpoint_if import temp_ctrl_pkg::*; #(
  parameter int SP_W = SP_W_DEF
);
  logic            key1_in;
  logic            key2_in;
  logic            key3_in;
  logic [SP_W-1:0] setpoint;
  logic [SP_W-1:0] edit_value;
  logic            editing;
  logic            blink;
  logic            sp_update;

  modport master (
    output key1_in, key2_in, key3_in,
    input  setpoint, edit_value, editing, blink, sp_update
  );

  modport slave (
    input  key1_in, key2_in, key3_in,
    output setpoint, edit_value, editing, blink, sp_update
  );
endinterface

// File: rtl/key_edge_det.sv
// Registered rising-edge detector for a small bundle of level key pulses.
// edge_o is high for the first sampled-high cycle of each pulse only.
module key_edge_det #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] key_i,
  output logic [W-1:0] edge_o
);
  logic [W-1:0] key_q;

  // Previous-cycle key levels
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= {W{1'b0}};
    end else begin
      key_q <= key_i;
    end
  end

  assign edge_o = key_i & ~key_q;
endmodule

// File: rtl/key_setpoint.sv
// Setpoint edit session driven by debounced mode/up/down key pulses.
// Define SETPOINT_TIMEOUT_EN to abandon an idle edit after TIMEOUT_CYC cycles.
module key_setpoint import temp_ctrl_pkg::*; #(
  parameter int SP_W        = SP_W_DEF,
  parameter int SP_MIN      = SP_MIN_DEF,
  parameter int SP_MAX      = SP_MAX_DEF,
  parameter int SP_DEFAULT  = SP_DEFAULT_DEF,
  parameter int STEP        = 1,
  parameter int TIMEOUT_CYC = 500000,
  parameter int BLINK_CYC   = 250000
) (
  input logic           clk,
  input logic           rst,
  key_setpoint_if.slave bus
);
  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_EDIT   = EDIT;
  localparam logic [1:0] S_COMMIT = COMMIT;
  localparam int         BCNT_W   = $clog2(BLINK_CYC + 1);

  logic [2:0]        key_s;
  logic [2:0]        edge_s;
  logic [1:0]        state_q, state_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [SP_W-1:0]   ev_q, ev_d;
  logic              editing_q, editing_d;
  logic              blink_q, blink_d;
  logic              upd_q, upd_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [SP_W:0]     inc_s;
  logic [SP_W:0]     dec_floor_s;
  logic [SP_W-1:0]   inc_sat_s;
  logic [SP_W-1:0]   dec_sat_s;
`ifdef SETPOINT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]  tmo_q, tmo_d;
`else
  logic              unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT_CYC;
`endif

  assign key_s = {bus.key3_in, bus.key2_in, bus.key1_in};

  key_edge_det #(.W(3)) u_edge (
    .clk    (clk),
    .rst    (rst),
    .key_i  (key_s),
    .edge_o (edge_s)
  );

  // Saturating steps computed one bit wider so neither end can wrap.
  assign inc_s       = {1'b0, ev_q} + (SP_W+1)'(STEP);
  assign inc_sat_s   = (inc_s > (SP_W+1)'(SP_MAX)) ? SP_W'(SP_MAX) : inc_s[SP_W-1:0];
  assign dec_floor_s = (SP_W+1)'(SP_MIN) + (SP_W+1)'(STEP);
  assign dec_sat_s   = ({1'b0, ev_q} < dec_floor_s) ? SP_W'(SP_MIN) : ev_q - SP_W'(STEP);

  // Edit-session next state; key1 > key2 > key3 with one action per cycle
  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    ev_d      = ev_q;
    editing_d = editing_q;
    blink_d   = blink_q;
    bcnt_d    = bcnt_q;
    upd_d     = 1'b0;
`ifdef SETPOINT_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (edge_s[0]) begin
          state_d   = S_EDIT;
          ev_d      = sp_q;
          editing_d = 1'b1;
          blink_d   = 1'b1;
          bcnt_d    = {BCNT_W{1'b0}};
`ifdef SETPOINT_TIMEOUT_EN
          tmo_d     = {TMO_W{1'b0}};
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EDIT: begin
        if (bcnt_q == BCNT_W'(BLINK_CYC - 1)) begin
          blink_d = ~blink_q;
          bcnt_d  = {BCNT_W{1'b0}};
        end else begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
`ifdef SETPOINT_TIMEOUT_EN
        tmo_d = {TMO_W{1'b0}};
`endif
        if (edge_s[0]) begin
          state_d   = S_COMMIT;
          editing_d = 1'b0;
          blink_d   = 1'b0;
          bcnt_d    = {BCNT_W{1'b0}};
        end else if (edge_s[1]) begin
          ev_d = inc_sat_s;
        end else if (edge_s[2]) begin
          ev_d = dec_sat_s;
        end else begin
`ifdef SETPOINT_TIMEOUT_EN
          if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            state_d   = S_IDLE;
            ev_d      = sp_q;
            editing_d = 1'b0;
            blink_d   = 1'b0;
            bcnt_d    = {BCNT_W{1'b0}};
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
`else
          state_d = S_EDIT;
`endif
        end
      end
      S_COMMIT: begin
        sp_d    = ev_q;
        upd_d   = (ev_q != sp_q);
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        ev_d      = sp_q;
        editing_d = 1'b0;
        blink_d   = 1'b0;
        bcnt_d    = {BCNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sp_q      <= SP_W'(SP_DEFAULT);
      ev_q      <= SP_W'(SP_DEFAULT);
      editing_q <= 1'b0;
      blink_q   <= 1'b0;
      upd_q     <= 1'b0;
      bcnt_q    <= {BCNT_W{1'b0}};
`ifdef SETPOINT_TIMEOUT_EN
      tmo_q     <= {TMO_W{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      ev_q      <= ev_d;
      editing_q <= editing_d;
      blink_q   <= blink_d;
      upd_q     <= upd_d;
      bcnt_q    <= bcnt_d;
`ifdef SETPOINT_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign bus.setpoint   = sp_q;
  assign bus.edit_value = ev_q;
  assign bus.editing    = editing_q;
  assign bus.blink      = blink_q;
  assign bus.sp_update  = upd_q;
endmodule

// File: tb/tb_key_setpoint.sv
// Self-checking bench for key_setpoint: committed setpoints go through an
// expected-value queue that is drained whenever sp_update pulses.
module tb_key_setpoint;
  import temp_ctrl_pkg::*;

  localparam int TMO = 100;
  localparam int BLK = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_setpoint_if bus ();

  key_setpoint #(
    .TIMEOUT_CYC (TMO),
    .BLINK_CYC   (BLK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_chk    = 0;
  int          n_fail   = 0;
  int          upd_seen = 0;
  int          upd_exp  = 0;
  logic        prev_upd = 1'b0;
  int unsigned exp_q[$];

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_commit(input int unsigned v);
    exp_q.push_back(v);
    upd_exp++;
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      1:       bus.key1_in = v;
      2:       bus.key2_in = v;
      default: bus.key3_in = v;
    endcase
  endtask

  task automatic press(input int k, input int len);
    @(negedge clk);
    set_key(k, 1'b1);
    repeat (len) @(negedge clk);
    set_key(k, 1'b0);
    @(negedge clk);
  endtask

  // Scoreboard drain on every sp_update pulse
  always @(negedge clk) begin
    if (bus.sp_update === 1'b1) begin
      upd_seen <= upd_seen + 1;
      check_val("sp_update_width", prev_upd, 0);
      if (exp_q.size() != 0) check_val("sp_update_setpoint", bus.setpoint, exp_q.pop_front());
      else check_val("sp_update_unexpected", bus.sp_update, 0);
    end
    prev_upd <= bus.sp_update;
  end

  initial begin
    rst = 1'b1;
    bus.key1_in = 1'b0;
    bus.key2_in = 1'b0;
    bus.key3_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_val("rst_setpoint", bus.setpoint, 25);
    check_val("rst_edit_value", bus.edit_value, 25);
    check_val("rst_editing", bus.editing, 0);
    check_val("rst_blink", bus.blink, 0);
    check_val("rst_sp_update", bus.sp_update, 0);

    // Timeout measured from the last (key2) edge
    press(1, 6);
    check_val("tmo_enter_editing", bus.editing, 1);
    @(negedge clk);
    bus.key2_in = 1'b1;
    @(negedge clk);
    bus.key2_in = 1'b0;
    check_val("tmo_edit_value", bus.edit_value, 26);
    repeat (TMO - 1) @(negedge clk);
    check_val("tmo_before_limit", bus.editing, 1);
    @(negedge clk);
`ifdef SETPOINT_TIMEOUT_EN
    check_val("tmo_editing", bus.editing, 0);
    check_val("tmo_blink", bus.blink, 0);
    check_val("tmo_edit_value_restored", bus.edit_value, 25);
`else
    check_val("no_tmo_editing", bus.editing, 1);
    repeat (900) @(negedge clk);
    check_val("no_tmo_editing_1000", bus.editing, 1);
    press(3, 2);
    press(1, 2);
    check_val("no_tmo_exit_editing", bus.editing, 0);
`endif
    check_val("tmo_setpoint", bus.setpoint, 25);

    // Basic edit: +3 and commit
    press(1, 6);
    for (int i = 0; i < 3; i++) press(2, 3);
    check_val("basic_edit_value", bus.edit_value, 28);
    check_val("basic_editing", bus.editing, 1);
    expect_commit(28);
    press(1, 2);
    check_val("basic_setpoint", bus.setpoint, 28);
    check_val("basic_editing_done", bus.editing, 0);
    check_val("basic_edit_value_done", bus.edit_value, 28);

    // key1 and key2 rising together: commit only
    press(1, 2);
    press(2, 2);
    check_val("simul_pre_value", bus.edit_value, 29);
    expect_commit(29);
    @(negedge clk);
    bus.key1_in = 1'b1;
    bus.key2_in = 1'b1;
    @(negedge clk);
    check_val("simul_editing", bus.editing, 0);
    check_val("simul_edit_value", bus.edit_value, 29);
    repeat (3) @(negedge clk);
    bus.key1_in = 1'b0;
    bus.key2_in = 1'b0;
    @(negedge clk);
    check_val("simul_setpoint", bus.setpoint, 29);

    // Blink phase from entry, then a 50-cycle held key2
    @(negedge clk);
    bus.key1_in = 1'b1;
    @(negedge clk);
    bus.key1_in = 1'b0;
    check_val("blink_entry_editing", bus.editing, 1);
    check_val("blink_entry", bus.blink, 1);
    repeat (BLK - 1) @(negedge clk);
    check_val("blink_last_high", bus.blink, 1);
    @(negedge clk);
    check_val("blink_toggle_low", bus.blink, 0);
    bus.key2_in = 1'b1;
    repeat (50) @(negedge clk);
    bus.key2_in = 1'b0;
    @(negedge clk);
    check_val("held_key2_value", bus.edit_value, 30);
    expect_commit(30);
    press(1, 2);
    check_val("held_setpoint", bus.setpoint, 30);

    // Saturation at both ends of the range
    press(1, 2);
    for (int i = 0; i < 68; i++) press(2, 1);
    check_val("sat_at_98", bus.edit_value, 98);
    for (int i = 0; i < 3; i++) press(2, 1);
    check_val("sat_high", bus.edit_value, 99);
    for (int i = 0; i < 98; i++) press(3, 1);
    check_val("sat_at_1", bus.edit_value, 1);
    for (int i = 0; i < 3; i++) press(3, 1);
    check_val("sat_low", bus.edit_value, 0);
    expect_commit(0);
    press(1, 2);
    check_val("sat_setpoint", bus.setpoint, 0);

    // Reset in the middle of an edit
    press(1, 2);
    for (int i = 0; i < 40; i++) press(2, 1);
    check_val("midrst_edit_value", bus.edit_value, 40);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_setpoint", bus.setpoint, 25);
    check_val("midrst_edit_value_after", bus.edit_value, 25);
    check_val("midrst_editing", bus.editing, 0);
    check_val("midrst_blink", bus.blink, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check_val("sp_update_count", upd_seen, upd_exp);
    check_val("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
